// File: rtl/pps_gen.sv
// pps_gen: five-channel test PPS generator on the 250 MHz serializer clock.
// A shared period counter marks the 1 s grid; each channel owns a 30-bit
// offset in ns, split into a 4 ns coarse cycle and a 1 ns lane position.
// Pulse width is timed by a per-channel down-counter, so a pulse that
// spans the period wrap finishes cleanly and is never retriggered.
// Offsets are double-buffered and only take effect at a period boundary.

module pps_gen #(
    parameter int PERIOD_CYC = 250000000,
    parameter int WIDTH_CYC  = 25000000
) (
    input  logic        i_pclk,
    input  logic        i_res_250m_n,
    input  logic        i_en,
    input  logic        i_align,
    input  logic        i_wr_en,
    input  logic [2:0]  i_wr_ch,
    input  logic [29:0] i_wr_ofs,
    output logic        o_wr_err,
    output logic        o_sync,
    output logic [19:0] o_dt20b
);

    localparam int          NCH       = 5;
    localparam logic [27:0] LAST_CNT  = 28'(PERIOD_CYC - 1);
    localparam logic [27:0] RUN_LOAD  = 28'(WIDTH_CYC - 1);
    localparam logic [31:0] OFS_LIMIT = 32'(PERIOD_CYC) * 32'd4;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HIGH = 1'b1
    } ch_state_t;

    // First word of a pulse: lanes fine..3 high (lane 0 leaves the wire first).
    function automatic logic [3:0] start_word(input logic [1:0] fine);
        start_word = 4'hF << fine;
    endfunction

    // Last word of a pulse: lanes 0..fine-1 high, completing 4*WIDTH_CYC lanes.
    function automatic logic [3:0] tail_word(input logic [1:0] fine);
        tail_word = ~start_word(fine);
    endfunction

    logic [27:0]            cnt_r;
    logic [27:0]            cnt_nxt_s;
    logic [NCH-1:0][29:0]   shadow_r;
    logic [NCH-1:0][29:0]   shadow_nxt_s;
    logic [NCH-1:0][29:0]   active_r;
    logic [NCH-1:0][27:0]   run_r;
    logic [NCH-1:0][27:0]   run_nxt_s;
    ch_state_t              state_r     [NCH];
    ch_state_t              state_nxt_s [NCH];
    logic [19:0]            dt_nxt_s;
    logic                   wr_ok_s;
    logic                   wrap_s;
    logic                   copy_s;

    assign wr_ok_s = i_wr_en && (i_wr_ch <= 3'd4) && ({2'b00, i_wr_ofs} < OFS_LIMIT);
    assign wrap_s  = i_en && (cnt_r == LAST_CNT);
    assign copy_s  = i_align || wrap_s;

    // Period counter next value: held at 0 while disabled, align beats wrap.
    always_comb begin
        cnt_nxt_s = cnt_r;
        if (!i_en) begin
            cnt_nxt_s = 28'd0;
        end else if (i_align || wrap_s) begin
            cnt_nxt_s = 28'd0;
        end else begin
            cnt_nxt_s = cnt_r + 28'd1;
        end
    end

    // Period counter register.
    always_ff @(posedge i_pclk or negedge i_res_250m_n) begin
        if (!i_res_250m_n) begin
            cnt_r <= 28'd0;
        end else begin
            cnt_r <= cnt_nxt_s;
        end
    end

    // Shadow offsets with this cycle's accepted write merged in, so a write
    // landing on the boundary cycle is part of the copy to active.
    always_comb begin
        shadow_nxt_s = shadow_r;
        for (int c = 0; c < NCH; c++) begin
            if (wr_ok_s && (i_wr_ch == 3'(c))) begin
                shadow_nxt_s[c] = i_wr_ofs;
            end else begin
                shadow_nxt_s[c] = shadow_r[c];
            end
        end
    end

    // Shadow and active offset registers; active only changes at a period start.
    always_ff @(posedge i_pclk or negedge i_res_250m_n) begin
        if (!i_res_250m_n) begin
            shadow_r <= '0;
            active_r <= '0;
        end else begin
            shadow_r <= shadow_nxt_s;
            if (copy_s) begin
                active_r <= shadow_nxt_s;
            end
        end
    end

    // Per-channel pulse FSMs: next state, width counter and lane word.
    always_comb begin
        dt_nxt_s = 20'd0;
        for (int c = 0; c < NCH; c++) begin
            state_nxt_s[c] = state_r[c];
            run_nxt_s[c]   = run_r[c];
            if (!i_en || i_align) begin
                // Disable truncates; align aborts so the channel restarts on the new grid.
                state_nxt_s[c] = ST_IDLE;
            end else begin
                case (state_r[c])
                    ST_IDLE: begin
                        if (cnt_r == active_r[c][29:2]) begin
                            dt_nxt_s[4*c +: 4] = start_word(active_r[c][1:0]);
                            run_nxt_s[c]       = RUN_LOAD;
                            state_nxt_s[c]     = ST_HIGH;
                        end else begin
                            state_nxt_s[c] = ST_IDLE;
                        end
                    end
                    ST_HIGH: begin
                        if (run_r[c] != 28'd0) begin
                            dt_nxt_s[4*c +: 4] = 4'hF;
                            run_nxt_s[c]       = run_r[c] - 28'd1;
                        end else begin
                            dt_nxt_s[4*c +: 4] = tail_word(active_r[c][1:0]);
                            state_nxt_s[c]     = ST_IDLE;
                        end
                    end
                    default: begin
                        state_nxt_s[c] = ST_IDLE;
                    end
                endcase
            end
        end
    end

    // FSM state, width counters and the registered serializer word.
    always_ff @(posedge i_pclk or negedge i_res_250m_n) begin
        if (!i_res_250m_n) begin
            for (int c = 0; c < NCH; c++) begin
                state_r[c] <= ST_IDLE;
            end
            run_r   <= '0;
            o_dt20b <= 20'd0;
        end else begin
            for (int c = 0; c < NCH; c++) begin
                state_r[c] <= state_nxt_s[c];
            end
            run_r   <= run_nxt_s;
            o_dt20b <= dt_nxt_s;
        end
    end

    // Registered status: sync lines up with the word produced from cnt==0.
    always_ff @(posedge i_pclk or negedge i_res_250m_n) begin
        if (!i_res_250m_n) begin
            o_sync   <= 1'b0;
            o_wr_err <= 1'b0;
        end else begin
            o_sync   <= i_en && (cnt_r == 28'd0);
            o_wr_err <= i_wr_en && !wr_ok_s;
        end
    end

endmodule

// File: tb/tb_pps_gen.sv
// Bench for pps_gen with a 100-cycle period and 10-cycle pulse width.
// The reference model tracks each pulse as an absolute interval of 1 ns
// lane slots and derives every expected output word from it.

module tb_pps_gen;

    localparam int P = 100;
    localparam int W = 10;

    logic        i_pclk = 1'b0;
    logic        i_res_250m_n;
    logic        i_en;
    logic        i_align;
    logic        i_wr_en;
    logic [2:0]  i_wr_ch;
    logic [29:0] i_wr_ofs;
    logic        o_wr_err;
    logic        o_sync;
    logic [19:0] o_dt20b;

    int total = 0;
    int bad   = 0;

    pps_gen #(.PERIOD_CYC(P), .WIDTH_CYC(W)) dut (
        .i_pclk       (i_pclk),
        .i_res_250m_n (i_res_250m_n),
        .i_en         (i_en),
        .i_align      (i_align),
        .i_wr_en      (i_wr_en),
        .i_wr_ch      (i_wr_ch),
        .i_wr_ofs     (i_wr_ofs),
        .o_wr_err     (o_wr_err),
        .o_sync       (o_sync),
        .o_dt20b      (o_dt20b)
    );

    always #2 i_pclk = ~i_pclk;

    task automatic check(input string nm, input logic [19:0] act, input logic [19:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, req);
        end
    endtask

    // ---------------- reference model ----------------
    int      m_cyc = 0;
    int      m_cnt;
    int      m_shadow [5];
    int      m_active [5];
    bit      m_on     [5];
    longint  m_start  [5];
    longint  m_end    [5];
    int      m_trig   [5];
    logic [19:0] exp_dt;
    logic        exp_sync;
    logic        exp_err;

    initial begin
        forever begin
            @(posedge i_pclk);
            exp_dt   = 20'd0;
            exp_sync = 1'b0;
            exp_err  = 1'b0;
            if (!i_res_250m_n) begin
                m_cnt = 0;
                for (int c = 0; c < 5; c++) begin
                    m_shadow[c] = 0;
                    m_active[c] = 0;
                    m_on[c]     = 1'b0;
                end
            end else begin
                if (!i_en || i_align) begin
                    for (int c = 0; c < 5; c++) m_on[c] = 1'b0;
                end else begin
                    for (int c = 0; c < 5; c++) begin
                        if (!m_on[c] && (m_cnt == m_active[c] / 4)) begin
                            m_on[c]    = 1'b1;
                            m_start[c] = 4 * longint'(m_cyc + 1) + longint'(m_active[c] % 4);
                            m_end[c]   = m_start[c] + 4 * W;
                            m_trig[c]  = m_cyc;
                        end
                        if (m_on[c]) begin
                            for (int l = 0; l < 4; l++) begin
                                longint lane;
                                lane = 4 * longint'(m_cyc + 1) + l;
                                if (lane >= m_start[c] && lane < m_end[c]) exp_dt[4*c+l] = 1'b1;
                            end
                            if (m_cyc >= m_trig[c] + W) m_on[c] = 1'b0;
                        end
                    end
                end
                exp_sync = i_en && (m_cnt == 0);
                exp_err  = i_wr_en && ((i_wr_ch > 3'd4) || (int'(i_wr_ofs) >= 4 * P));
                if (i_wr_en && !exp_err) m_shadow[i_wr_ch] = int'(i_wr_ofs);
                if (i_align || (i_en && m_cnt == P - 1)) begin
                    for (int c = 0; c < 5; c++) m_active[c] = m_shadow[c];
                end
                if (!i_en || i_align) m_cnt = 0;
                else m_cnt = (m_cnt + 1) % P;
            end
            m_cyc++;
            #1;
            check($sformatf("dt20b@%0d", m_cyc), o_dt20b, exp_dt);
            check($sformatf("sync@%0d", m_cyc), {19'd0, o_sync}, {19'd0, exp_sync});
            check($sformatf("wr_err@%0d", m_cyc), {19'd0, o_wr_err}, {19'd0, exp_err});
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic tick(input int n);
        repeat (n) @(negedge i_pclk);
    endtask

    task automatic wait_sync(input string nm);
        bit found;
        found = 1'b0;
        for (int i = 0; i < 250 && !found; i++) begin
            @(negedge i_pclk);
            if (o_sync) found = 1'b1;
        end
        total++;
        if (!found) begin
            bad++;
            $display("FAIL %s: got no o_sync within 250 cycles, required one", nm);
        end
    endtask

    task automatic write(input logic [2:0] ch, input logic [29:0] ofs);
        i_wr_en  = 1'b1;
        i_wr_ch  = ch;
        i_wr_ofs = ofs;
        tick(1);
        i_wr_en  = 1'b0;
    endtask

    initial begin
        i_res_250m_n = 1'b0;
        i_en     = 1'b0;
        i_align  = 1'b0;
        i_wr_en  = 1'b0;
        i_wr_ch  = 3'd0;
        i_wr_ofs = 30'd0;
        tick(3);
        check("reset_dt", o_dt20b, 20'd0);
        check("reset_sync", {19'd0, o_sync}, 20'd0);
        check("reset_err", {19'd0, o_wr_err}, 20'd0);
        i_res_250m_n = 1'b1;
        tick(2);
        i_en = 1'b1;

        // all offsets 0: every channel high for 10 cycles from the sync cycle
        wait_sync("first_sync");
        check("all_hi_first", o_dt20b, 20'hFFFFF);
        tick(9);
        check("all_hi_last", o_dt20b, 20'hFFFFF);
        tick(1);
        check("all_lo_after", o_dt20b, 20'h00000);
        tick(89);
        check("no_sync_99", {19'd0, o_sync}, 20'd0);
        tick(1);
        check("sync_period", {19'd0, o_sync}, 20'd1);

        // ch1 offset 41 ns: coarse 10, fine 1
        tick(2);
        write(3'd1, 30'd41);
        check("wr_ok_no_err", {19'd0, o_wr_err}, 20'd0);
        wait_sync("sync_b");
        check("ch1_idle_at_sync", {16'd0, o_dt20b[7:4]}, 20'h0);
        tick(10);
        check("ch1_start", {16'd0, o_dt20b[7:4]}, 20'hE);
        tick(10);
        check("ch1_tail", {16'd0, o_dt20b[7:4]}, 20'h1);
        tick(1);
        check("ch1_done", {16'd0, o_dt20b[7:4]}, 20'h0);

        // ch4 offset 396 ns: starts at cnt 99 and runs across the wrap
        write(3'd4, 30'd396);
        wait_sync("sync_c");
        tick(99);
        check("ch4_start", {16'd0, o_dt20b[19:16]}, 20'hF);
        tick(1);
        check("ch4_wrap_sync", {19'd0, o_sync}, 20'd1);
        check("ch4_wrap_hi", {16'd0, o_dt20b[19:16]}, 20'hF);
        tick(8);
        check("ch4_last_hi", {16'd0, o_dt20b[19:16]}, 20'hF);
        tick(1);
        check("ch4_tail", {16'd0, o_dt20b[19:16]}, 20'h0);

        // rejected writes (now 9 cycles after sync D)
        i_wr_en  = 1'b1;
        i_wr_ch  = 3'd2;
        i_wr_ofs = 30'd400;
        tick(1);
        check("err_ofs", {19'd0, o_wr_err}, 20'd1);
        i_wr_ch  = 3'd5;
        i_wr_ofs = 30'd0;
        tick(1);
        check("err_ch", {19'd0, o_wr_err}, 20'd1);
        i_wr_en  = 1'b0;
        tick(1);
        check("err_clear", {19'd0, o_wr_err}, 20'd0);

        // ch0 offset 8 written while cnt==99 (D+98)
        tick(86);
        write(3'd0, 30'd8);
        tick(1);
        check("e_sync", {19'd0, o_sync}, 20'd1);
        check("ch0_not_yet", {16'd0, o_dt20b[3:0]}, 20'h0);
        tick(2);
        check("ch0_new_ofs", {16'd0, o_dt20b[3:0]}, 20'hF);

        // align while ch1 is high (E+12)
        tick(10);
        i_align = 1'b1;
        tick(1);
        i_align = 1'b0;
        check("align_abort", {16'd0, o_dt20b[7:4]}, 20'h0);
        check("align_no_sync_yet", {19'd0, o_sync}, 20'd0);
        tick(1);
        check("align_sync", {19'd0, o_sync}, 20'd1);
        tick(10);
        check("ch1_after_align", {16'd0, o_dt20b[7:4]}, 20'hE);

        // disable mid-pulse, then re-enable
        wait_sync("sync_g");
        tick(3);
        i_en = 1'b0;
        tick(1);
        check("en_off_trunc", o_dt20b, 20'h00000);
        tick(5);
        check("en_off_dt", o_dt20b, 20'h00000);
        check("en_off_sync", {19'd0, o_sync}, 20'd0);
        i_en = 1'b1;
        tick(1);
        check("en_resync", {19'd0, o_sync}, 20'd1);
        check("en_ch2_hi", {16'd0, o_dt20b[11:8]}, 20'hF);

        // asynchronous reset in the middle of a pulse
        tick(2);
        check("pre_rst_hi", {16'd0, o_dt20b[11:8]}, 20'hF);
        i_res_250m_n = 1'b0;
        #1;
        check("rst_async_dt", o_dt20b, 20'h00000);
        check("rst_async_sync", {19'd0, o_sync}, 20'd0);
        tick(2);
        i_res_250m_n = 1'b1;
        tick(3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
